// File: rtl/lockstep_alu_chk.sv
// Dual-channel lockstep ALU with a 2-stage pipeline, result comparator and OK/SUSPECT/FAULT monitor.
// Optional cumulative mismatch counter on err_cnt, enabled by defining LOCKSTEP_ERR_CNT_EN.
module lockstep_alu_chk #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FAULT_THRESH = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       sel0,
  input  logic [1:0]       sel1,
  input  logic             in_valid,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic             cout0,
  output logic             cout1,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             cdiff,
  output logic             mismatch,
  output logic             suspect,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned RUN_W = (FAULT_THRESH < 2) ? 1 : $clog2(FAULT_THRESH + 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} state_t;

  logic [WIDTH-1:0] a0_q, b0_q, a1_q, b1_q;
  logic [1:0]       sel0_q, sel1_q;
  logic             v1_q;
  logic [WIDTH:0]   alu0, alu1;
  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;

  // Result carries the carry/borrow in bit WIDTH; subtraction borrows when a < b.
  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic [1:0] sel);
    case (sel)
      2'b00:   alu = {1'b0, a} + {1'b0, b};
      2'b01:   alu = {1'b0, a} - {1'b0, b};
      2'b10:   alu = {1'b0, a & b};
      default: alu = {1'b0, a | b};
    endcase
  endfunction

  // Stage 1: operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q   <= '0;
      b0_q   <= '0;
      a1_q   <= '0;
      b1_q   <= '0;
      sel0_q <= '0;
      sel1_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      a0_q   <= a0;
      b0_q   <= b0;
      a1_q   <= a1;
      b1_q   <= b1;
      sel0_q <= sel0;
      sel1_q <= sel1;
      v1_q   <= in_valid;
    end
  end

  assign alu0 = alu(a0_q, b0_q, sel0_q);
  assign alu1 = alu(a1_q, b1_q, sel1_q);

  // Stage 2: result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0      <= '0;
      res1      <= '0;
      cout0     <= 1'b0;
      cout1     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      res0      <= alu0[WIDTH-1:0];
      res1      <= alu1[WIDTH-1:0];
      cout0     <= alu0[WIDTH];
      cout1     <= alu1[WIDTH];
      out_valid <= v1_q;
    end
  end

  assign diff     = res0 ^ res1;
  assign cdiff    = cout0 ^ cout1;
  assign mismatch = out_valid & ((|diff) | cdiff);

  // Monitor state register; flags track the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OK;
      run_cnt <= '0;
      suspect <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      suspect <= (state_nxt == ST_SUSPECT);
      fault   <= (state_nxt == ST_FAULT);
    end
  end

  // Cycles without out_valid fall through every branch, so state and run_cnt hold across gaps
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    case (state)
      ST_OK: begin
        if (mismatch) begin
          run_nxt   = RUN_W'(1);
          state_nxt = (FAULT_THRESH <= 1) ? ST_FAULT : ST_SUSPECT;
        end
      end
      ST_SUSPECT: begin
        if (mismatch) begin
          run_nxt = run_cnt + RUN_W'(1);
          if (run_nxt >= RUN_W'(FAULT_THRESH)) state_nxt = ST_FAULT;
        end else if (out_valid) begin
          run_nxt   = '0;
          state_nxt = ST_OK;
        end
      end
      ST_FAULT: begin
        if (clr_fault) begin
          run_nxt   = '0;
          state_nxt = ST_OK;
        end
      end
      default: begin
        run_nxt   = '0;
        state_nxt = ST_OK;
      end
    endcase
  end

`ifdef LOCKSTEP_ERR_CNT_EN
  // Saturating count of mismatch cycles, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_lockstep_alu_chk.sv
// Scoreboard bench for lockstep_alu_chk: queued expected results, behavioural monitor model,
// directed add/sub/mismatch/threshold/clear/reset/saturation scenarios.
module tb_lockstep_alu_chk;

  localparam int unsigned W  = 8;
  localparam int unsigned TH = 2;
  localparam int unsigned CW = 8;
`ifdef LOCKSTEP_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [1:0]    sel0, sel1;
  logic          in_valid, clr_fault;
  logic [W-1:0]  res0, res1, diff;
  logic          cout0, cout1, out_valid, cdiff, mismatch, suspect, fault;
  logic [CW-1:0] err_cnt;

  lockstep_alu_chk #(.WIDTH(W), .FAULT_THRESH(TH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sel0(sel0), .sel1(sel1), .in_valid(in_valid), .clr_fault(clr_fault),
    .res0(res0), .res1(res1), .cout0(cout0), .cout1(cout1), .out_valid(out_valid),
    .diff(diff), .cdiff(cdiff), .mismatch(mismatch), .suspect(suspect), .fault(fault),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic         c0;
    logic         c1;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   m_st   = 0;  // 0 OK, 1 SUSPECT, 2 FAULT
  int   m_run  = 0;
  int   m_err  = 0;
  bit   pv     = 1'b0;
  bit   pm     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic ref_alu(input int a, input int b, input int sel,
                         output logic [W-1:0] r, output logic c);
    int mask;
    mask = (1 << W) - 1;
    case (sel)
      0: begin r = W'((a + b) & mask); c = ((a + b) > mask); end
      1: begin r = W'((a - b) & mask); c = (a < b); end
      2: begin r = W'(a & b); c = 1'b0; end
      default: begin r = W'(a | b); c = 1'b0; end
    endcase
  endtask

  task automatic send(input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic [1:0] xs0,
                      input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic [1:0] xs1);
    exp_t e;
    @(negedge clk);
    a0 = xa0; b0 = xb0; sel0 = xs0;
    a1 = xa1; b1 = xb1; sel1 = xs1;
    in_valid  = 1'b1;
    clr_fault = 1'b0;
    ref_alu(int'(xa0), int'(xb0), int'(xs0), e.r0, e.c0);
    ref_alu(int'(xa1), int'(xb1), int'(xs1), e.r1, e.c1);
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit clr);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      clr_fault = clr;
    end
  endtask

  task automatic send_mm();
    send(8'h0F, 8'h01, 2'b00, 8'h0F, 8'h01, 2'b11);
  endtask

  task automatic send_ok();
    send(8'h33, 8'h44, 2'b00, 8'h33, 8'h44, 2'b00);
  endtask

  // Monitor: steps the behavioural model on each edge, then scores the outputs
  initial begin
    exp_t e;
    bit   emm;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        m_st = 0; m_run = 0; m_err = 0; pv = 1'b0; pm = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (m_st == 2) begin
          if (clr_fault) begin m_st = 0; m_run = 0; end
        end else if (pv && pm) begin
          m_run++;
          m_st = (m_run >= TH) ? 2 : 1;
        end else if (pv && m_st == 1) begin
          m_st = 0; m_run = 0;
        end
        if (pv && pm && m_err < (1 << CW) - 1) m_err++;
        check("suspect", 32'(suspect), 32'(m_st == 1));
        check("fault", 32'(fault), 32'(m_st == 2));
        check("err_cnt", 32'(err_cnt), ERR_EN ? 32'(m_err) : 32'd0);
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
            pv = 1'b0; pm = 1'b0;
          end else begin
            e   = sb.pop_front();
            emm = (e.r0 != e.r1) || (e.c0 != e.c1);
            check("latency", 32'(cyc), 32'(e.due));
            check("res0", 32'(res0), 32'(e.r0));
            check("res1", 32'(res1), 32'(e.r1));
            check("cout0", 32'(cout0), 32'(e.c0));
            check("cout1", 32'(cout1), 32'(e.c1));
            check("diff", 32'(diff), 32'(e.r0 ^ e.r1));
            check("cdiff", 32'(cdiff), 32'(e.c0 ^ e.c1));
            check("mismatch", 32'(mismatch), 32'(emm));
            pv = 1'b1; pm = emm;
          end
        end else begin
          check("mismatch_idle", 32'(mismatch), 32'd0);
          pv = 1'b0; pm = 1'b0;
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_out_valid", 32'(out_valid), 32'd1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
    repeat (2) @(negedge clk);
    check("reset_res0", 32'(res0), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    idle(2, 1'b0);

    // Identical add with carry, subtract with borrow, then a random sweep of all ops
    send(8'hF0, 8'h20, 2'b00, 8'hF0, 8'h20, 2'b00);
    send(8'h05, 8'h07, 2'b01, 8'h05, 8'h07, 2'b01);
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      send(ra, rb, 2'(i % 4), ra, rb, 2'(i % 4));
    end
    idle(1, 1'b1);  // clr_fault while OK has no effect
    idle(3, 1'b0);

    // Single mismatch then a matching set
    send_mm();
    send_ok();
    idle(4, 1'b0);
    check("ok_after_match", 32'(suspect), 32'd0);

    // Mismatch, gap, mismatch reaches the threshold; fault then sticks
    send_mm();
    idle(1, 1'b0);
    send_mm();
    for (int i = 0; i < 10; i++) send_ok();
    idle(3, 1'b0);
    check("fault_sticky", 32'(fault), 32'd1);

    // clr_fault lands on the same edge as a mismatch
    send_mm();
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    check("clr_collision_fault", 32'(fault), 32'd0);
    check("clr_collision_suspect", 32'(suspect), 32'd0);
    send_mm();
    idle(4, 1'b0);
    check("run_restart_suspect", 32'(suspect), 32'd1);
    check("run_restart_fault", 32'(fault), 32'd0);

    // Reset with sets in flight
    send_mm();
    send_mm();
    send_mm();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0;
    sb.delete();
    #1;
    check("rst_now_out_valid", 32'(out_valid), 32'd0);
    check("rst_now_res0", 32'(res0), 32'd0);
    check("rst_now_res1", 32'(res1), 32'd0);
    check("rst_now_cout0", 32'(cout0), 32'd0);
    check("rst_now_mismatch", 32'(mismatch), 32'd0);
    check("rst_now_suspect", 32'(suspect), 32'd0);
    check("rst_now_fault", 32'(fault), 32'd0);
    check("rst_now_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4, 1'b0);
    send(8'hFF, 8'h01, 2'b00, 8'hFF, 8'h01, 2'b00);
    idle(4, 1'b0);

    // Long mismatch run saturates the counter
    for (int i = 0; i < 300; i++) send_mm();
    idle(4, 1'b0);
    check("err_cnt_saturated", 32'(err_cnt), ERR_EN ? 32'hFF : 32'd0);
    check("queue_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lockstep_alu_chk.md
LOCKSTEP_ALU_CHK -- requirements
Module: lockstep_alu_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (>=2).
REQ-002 SHALL have parameter FAULT_THRESH, default 2, consecutive mismatching results needed to declare fault (>=1).
REQ-003 SHALL have parameter CNT_W, default 8, width of the mismatch counter.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports a0, b0, a1, b1  in  WIDTH each  operands for channel 0 and channel 1.
REQ-007 SHALL have ports sel0, sel1  in  2 each  operation selects for channel 0 and channel 1.
REQ-008 SHALL have port in_valid  in  1  operand set present this cycle.
REQ-009 SHALL have port clr_fault  in  1  single-cycle request to clear the fault state.
REQ-010 SHALL have ports res0, res1  out  WIDTH each  registered channel results.
REQ-011 SHALL have ports cout0, cout1  out  1 each  registered carry/borrow flags.
REQ-012 SHALL have port out_valid  out  1  results and compare outputs valid.
REQ-013 SHALL have ports diff (WIDTH) and cdiff (1), both out  res0^res1 and cout0^cout1.
REQ-014 SHALL have port mismatch  out  1  out_valid AND (diff!=0 OR cdiff).
REQ-015 SHALL have ports suspect and fault, both out  1  FSM state flags.
REQ-016 SHALL have port err_cnt  out  CNT_W  mismatch counter (see Configuration).

Function
REQ-017 SHALL run a fixed 2-stage pipeline: stage 1 registers operands/selects/in_valid; stage 2 registers ALU results, so in_valid at edge N gives out_valid at edge N+2, with one new operand set accepted per cycle and no stall.
REQ-018 SHALL compute per channel, in WIDTH+1 bits: 00 A+B (cout = bit WIDTH); 01 A-B two's complement (cout = borrow, 1 when A<B); 10 A&B, cout=0; 11 A|B, cout=0.
REQ-019 SHALL ensure diff, cdiff and mismatch are combinational from stage-2 registers; mismatch is 0 whenever out_valid=0.
REQ-020 SHALL implement FSM states OK, SUSPECT and FAULT with a consecutive-mismatch counter run_cnt; suspect=(state==SUSPECT), fault=(state==FAULT).
REQ-021 SHALL, in OK on mismatch, set run_cnt=1 and go to FAULT if FAULT_THRESH==1, else to SUSPECT.
REQ-022 SHALL, in SUSPECT on mismatch, increment run_cnt and go to FAULT when run_cnt reaches FAULT_THRESH; on out_valid with no mismatch, go to OK with run_cnt=0.
REQ-023 SHALL keep FAULT sticky until clr_fault=1, which sends the FSM to OK with run_cnt=0.
REQ-024 SHALL hold state and run_cnt in any cycle with out_valid=0; gaps do not break a mismatch run.
REQ-025 SHALL give clr_fault priority over a simultaneous mismatch: the FSM goes to OK and that mismatch is not counted in run_cnt; clr_fault outside FAULT is ignored.

Reset
REQ-026 SHALL, on asserting rst, immediately clear all pipeline registers, drive res0/res1/cout0/cout1/out_valid/mismatch/suspect/fault to 0 and err_cnt to 0, and put the FSM in OK with run_cnt=0.
REQ-027 SHALL discard any operand sets in flight when rst asserts mid-operation; the first out_valid occurs 2 edges after the first in_valid sampled after release.

Configuration
REQ-028 SHALL, with macro LOCKSTEP_ERR_CNT_EN defined, make err_cnt a cumulative count of mismatch cycles that saturates at all-ones, is unaffected by clr_fault, and is cleared only by rst.
REQ-029 SHALL, without LOCKSTEP_ERR_CNT_EN, drive err_cnt constant 0 and include no counter logic.

Verification
REQ-030 SHALL cover identical add, both channels A=8'hF0 B=8'h20 sel=00 -> 2 cycles later res=8'h10, cout=1, diff=0, mismatch=0, state OK.
REQ-031 SHALL cover sub borrow, A=8'h05 B=8'h07 sel=01 both -> res=8'hFE, cout=1, no mismatch.
REQ-032 SHALL cover single mismatch, sel0=00 sel1=11 with A=8'h0F B=8'h01 -> res0=8'h10, res1=8'h0F, diff=8'h1F, mismatch=1, suspect=1; then a matching set -> OK.
REQ-033 SHALL cover threshold with gap, mismatch / idle cycle / mismatch (THRESH=2) -> fault=1 and stays 1 across 10 matching sets; err_cnt=2 if LOCKSTEP_ERR_CNT_EN.
REQ-034 SHALL cover clear collision, clr_fault in the same cycle as a mismatch while in FAULT -> state OK, run_cnt=0, suspect=0; err_cnt still increments.
REQ-035 SHALL cover reset mid-stream, rst asserted with two sets in flight -> outputs 0 at once, no out_valid for the flushed sets; err_cnt saturates at 8'hFF after 300 mismatches.
